tag_comparator: RTL and testbench

- Stage directly downstream of the index extractor in the DRAM cache controller.
- Pops one request record per transaction from the tag FIFO: {is_write, tid, full address}.
- Pairs that record with the in-order single-beat R response that the memory controller returns for the index read. Compares the stored tag/valid metadata against the request tag.
- Emits one hit/miss result per request to the response/miss-handling stage over a valid/ready channel.

---
 rtl/tag_comparator_pkg.sv | 49 ++++
 rtl/tag_comparator_tag_match.sv | 14 +
 rtl/tag_comparator.sv | 208 ++++++++++++++++++++
 tb/tb_tag_comparator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_comparator_pkg.sv
// Shared definitions for the DRAM cache tag path: index extractor, tag FIFO and tag comparator.
// Default geometry, derived tag/metadata widths, tag FIFO record and AXI response codes.
package tag_comparator_pkg;

    localparam int unsigned CFG_ADDR_WIDTH   = 64;
    localparam int unsigned CFG_ID_WIDTH     = 4;
    localparam int unsigned CFG_INDEX_WIDTH  = 20;
    localparam int unsigned CFG_OFFSET_WIDTH = 6;
    localparam int unsigned CFG_TID_WIDTH    = 16;
    localparam int unsigned CFG_DATA_WIDTH   = 512;

    localparam int unsigned CFG_TAG_WIDTH  = CFG_ADDR_WIDTH - CFG_INDEX_WIDTH - CFG_OFFSET_WIDTH;
    localparam int unsigned CFG_META_WIDTH = CFG_TAG_WIDTH + 2;
    localparam int unsigned CFG_LINE_WIDTH = CFG_DATA_WIDTH - CFG_META_WIDTH;
    localparam int unsigned CFG_REC_WIDTH  = CFG_ADDR_WIDTH + CFG_TID_WIDTH + 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic                      is_write;
        logic [CFG_TID_WIDTH-1:0]  tid;
        logic [CFG_ADDR_WIDTH-1:0] addr;
    } tag_rec_t;

    function automatic int unsigned calc_tag_width(input int unsigned addr_w,
                                                   input int unsigned index_w,
                                                   input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned calc_meta_width(input int unsigned tag_w);
        return tag_w + 2;
    endfunction

    // Metadata sits in the top bits of the R beat: {valid, dirty, tag}, line below it.
    function automatic int unsigned meta_valid_bit(input int unsigned data_w);
        return data_w - 1;
    endfunction

    function automatic int unsigned meta_dirty_bit(input int unsigned data_w);
        return data_w - 2;
    endfunction

    function automatic int unsigned meta_tag_lsb(input int unsigned data_w,
                                                 input int unsigned tag_w);
        return data_w - calc_meta_width(tag_w);
    endfunction

endpackage

// File: rtl/tag_comparator_tag_match.sv
// Combinational tag compare: hit only for a valid stored line whose tag matches and an OKAY read.
module tag_comparator_tag_match #(
    parameter int unsigned TAG_WIDTH = 38
) (
    input  logic                 i_valid,
    input  logic [TAG_WIDTH-1:0] i_stored_tag,
    input  logic [TAG_WIDTH-1:0] i_req_tag,
    input  logic                 i_err,
    output logic                 o_hit_c
);

    assign o_hit_c = i_valid && (i_stored_tag == i_req_tag) && !i_err;

endmodule

// File: rtl/tag_comparator.sv
// Tag comparator: pairs each popped tag FIFO record with the in-order index read beat, emits hit/miss.
// Optional hit/miss counters under `TAG_COMPARATOR_STATS_EN.
module tag_comparator
    import tag_comparator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = CFG_ADDR_WIDTH,
    parameter int unsigned ID_WIDTH     = CFG_ID_WIDTH,
    parameter int unsigned INDEX_WIDTH  = CFG_INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = CFG_OFFSET_WIDTH,
    parameter int unsigned TID_WIDTH    = CFG_TID_WIDTH,
    parameter int unsigned DATA_WIDTH   = CFG_DATA_WIDTH,
    localparam int unsigned TAG_WIDTH   = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH),
    localparam int unsigned LINE_WIDTH  = DATA_WIDTH - calc_meta_width(TAG_WIDTH),
    localparam int unsigned REC_WIDTH   = ADDR_WIDTH + TID_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tag_fifo_empty_i,
    output logic                  tag_fifo_rden_o,
    input  logic [REC_WIDTH-1:0]  tag_fifo_data_i,
    input  logic [ID_WIDTH-1:0]   rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic                  res_hit_o,
    output logic                  res_write_o,
    output logic [TID_WIDTH-1:0]  res_tid_o,
    output logic [ADDR_WIDTH-1:0] res_addr_o,
    output logic                  res_dirty_o,
    output logic [TAG_WIDTH-1:0]  res_victim_tag_o,
    output logic [LINE_WIDTH-1:0] res_data_o,
    output logic                  res_err_o
`ifdef TAG_COMPARATOR_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int unsigned VALID_BIT = meta_valid_bit(DATA_WIDTH);
    localparam int unsigned DIRTY_BIT = meta_dirty_bit(DATA_WIDTH);
    localparam int unsigned TAG_LSB   = meta_tag_lsb(DATA_WIDTH, TAG_WIDTH);
    localparam int unsigned REQ_TAG_LSB = INDEX_WIDTH + OFFSET_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_POP    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_rden;
    logic       r_rready;
    logic       r_res_valid;
    logic       w_rden_next;
    logic       w_rready_next;
    logic       w_res_valid_next;
    logic       w_latch_req;
    logic       w_accept;

    logic                  r_res_hit;
    logic                  r_res_write;
    logic [TID_WIDTH-1:0]  r_res_tid;
    logic [ADDR_WIDTH-1:0] r_res_addr;
    logic                  r_res_dirty;
    logic [TAG_WIDTH-1:0]  r_res_victim_tag;
    logic [LINE_WIDTH-1:0] r_res_data;
    logic                  r_res_err;

    logic                  w_err;
    logic                  w_hit_c;
    logic                  w_unused;

    assign w_err    = (rresp_i != RESP_OKAY);
    assign w_unused = ^{rid_i, rlast_i};

    tag_comparator_tag_match #(
        .TAG_WIDTH (TAG_WIDTH)
    ) u_tag_match (
        .i_valid      (rdata_i[VALID_BIT]),
        .i_stored_tag (rdata_i[TAG_LSB +: TAG_WIDTH]),
        .i_req_tag    (r_res_addr[REQ_TAG_LSB +: TAG_WIDTH]),
        .i_err        (w_err),
        .o_hit_c      (w_hit_c)
    );

    // Pop is issued from S_IDLE one cycle ahead of leaving it, so tag_fifo_rden_o stays registered.
    always_comb begin
        w_state_next     = r_state;
        w_rden_next      = 1'b0;
        w_rready_next    = 1'b0;
        w_res_valid_next = 1'b0;
        w_latch_req      = 1'b0;
        w_accept         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_rden) begin
                    w_state_next = S_POP;
                end else if (!tag_fifo_empty_i) begin
                    w_rden_next = 1'b1;
                end
            end
            S_POP: begin
                w_latch_req   = 1'b1;
                w_rready_next = 1'b1;
                w_state_next  = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (rvalid_i && r_rready) begin
                    w_accept         = 1'b1;
                    w_res_valid_next = 1'b1;
                    w_state_next     = S_OUT;
                end else begin
                    w_rready_next = 1'b1;
                end
            end
            S_OUT: begin
                if (res_ready_i) begin
                    w_rden_next  = !tag_fifo_empty_i;
                    w_state_next = S_IDLE;
                end else begin
                    w_res_valid_next = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rden      <= 1'b0;
            r_rready    <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rden      <= w_rden_next;
            r_rready    <= w_rready_next;
            r_res_valid <= w_res_valid_next;
        end
    end

    // Result payload only changes in S_POP / on R acceptance, so it is stable while res_valid_o is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_write      <= 1'b0;
            r_res_tid        <= '0;
            r_res_addr       <= '0;
            r_res_hit        <= 1'b0;
            r_res_dirty      <= 1'b0;
            r_res_victim_tag <= '0;
            r_res_data       <= '0;
            r_res_err        <= 1'b0;
        end else begin
            if (w_latch_req) begin
                r_res_write <= tag_fifo_data_i[REC_WIDTH-1];
                r_res_tid   <= tag_fifo_data_i[ADDR_WIDTH +: TID_WIDTH];
                r_res_addr  <= tag_fifo_data_i[ADDR_WIDTH-1:0];
            end
            if (w_accept) begin
                r_res_hit        <= w_hit_c;
                r_res_dirty      <= rdata_i[DIRTY_BIT];
                r_res_victim_tag <= rdata_i[TAG_LSB +: TAG_WIDTH];
                r_res_data       <= rdata_i[LINE_WIDTH-1:0];
                r_res_err        <= w_err;
            end
        end
    end

    assign tag_fifo_rden_o  = r_rden;
    assign rready_o         = r_rready;
    assign res_valid_o      = r_res_valid;
    assign res_hit_o        = r_res_hit;
    assign res_write_o      = r_res_write;
    assign res_tid_o        = r_res_tid;
    assign res_addr_o       = r_res_addr;
    assign res_dirty_o      = r_res_dirty;
    assign res_victim_tag_o = r_res_victim_tag;
    assign res_data_o       = r_res_data;
    assign res_err_o        = r_res_err;

`ifdef TAG_COMPARATOR_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Saturating per-handshake hit/miss counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_res_valid && res_ready_i) begin
            if (r_res_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_tag_comparator.sv
// Directed self-checking bench for tag_comparator with a small tag FIFO model.
module tb_tag_comparator;

    logic         clk;
    logic         rst_n;
    logic         tag_fifo_empty_i;
    logic         tag_fifo_rden_o;
    logic [80:0]  tag_fifo_data_i;
    logic [3:0]   rid_i;
    logic [511:0] rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic         rvalid_i;
    logic         rready_o;
    logic         res_valid_o;
    logic         res_ready_i;
    logic         res_hit_o;
    logic         res_write_o;
    logic [15:0]  res_tid_o;
    logic [63:0]  res_addr_o;
    logic         res_dirty_o;
    logic [37:0]  res_victim_tag_o;
    logic [471:0] res_data_o;
    logic         res_err_o;
`ifdef TAG_COMPARATOR_STATS_EN
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_pops = 0;
    int n_bad_pops = 0;

    logic [80:0]  fifo_q[$];
    logic         push_req;
    logic [80:0]  push_rec;

    tag_comparator dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tag_fifo_empty_i (tag_fifo_empty_i),
        .tag_fifo_rden_o  (tag_fifo_rden_o),
        .tag_fifo_data_i  (tag_fifo_data_i),
        .rid_i            (rid_i),
        .rdata_i          (rdata_i),
        .rresp_i          (rresp_i),
        .rlast_i          (rlast_i),
        .rvalid_i         (rvalid_i),
        .rready_o         (rready_o),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .res_hit_o        (res_hit_o),
        .res_write_o      (res_write_o),
        .res_tid_o        (res_tid_o),
        .res_addr_o       (res_addr_o),
        .res_dirty_o      (res_dirty_o),
        .res_victim_tag_o (res_victim_tag_o),
        .res_data_o       (res_data_o),
        .res_err_o        (res_err_o)
`ifdef TAG_COMPARATOR_STATS_EN
        ,
        .hit_cnt_o        (hit_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pop data appears the cycle after rden.
    always @(posedge clk) begin
        if (tag_fifo_rden_o) begin
            n_pops++;
            if (fifo_q.size() == 0) n_bad_pops++;
            else tag_fifo_data_i <= fifo_q.pop_front();
        end
        if (push_req) fifo_q.push_back(push_rec);
        tag_fifo_empty_i <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic is_w, input logic [15:0] tid, input logic [63:0] addr);
        @(negedge clk);
        push_rec = {is_w, tid, addr};
        push_req = 1'b1;
        @(negedge clk);
        push_req = 1'b0;
    endtask

    // Present one R beat until accepted, then wait for the result.
    task automatic serve(input logic v, input logic d, input logic [37:0] tag,
                         input logic [471:0] line, input logic [1:0] resp);
        logic ok;
        rdata_i  = {v, d, tag, line};
        rresp_i  = resp;
        rvalid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rready_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("rready_timeout", {511'd0, ok}, 512'd1);
        @(posedge clk);
        #1 rvalid_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("res_valid_timeout", {511'd0, ok}, 512'd1);
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        check("res_valid_drop", {511'd0, res_valid_o}, 512'd0);
    endtask

    logic [471:0] line_a;
    logic [471:0] line_b;
    logic [63:0]  addr_a;
    logic [63:0]  addr_b;
    logic [37:0]  tag_b;
    int           pops_before;
    logic         stable;

    initial begin
        rst_n = 1'b0;
        tag_fifo_empty_i = 1'b1;
        tag_fifo_data_i = '0;
        push_req = 1'b0;
        push_rec = '0;
        rid_i = 4'd0;
        rdata_i = '0;
        rresp_i = 2'b00;
        rlast_i = 1'b1;
        rvalid_i = 1'b0;
        res_ready_i = 1'b0;
        line_a = {59{8'hA5}};
        line_b = {59{8'h3C}};
        addr_a = 64'h0000_0040_0000_1240;
        addr_b = 64'h1234_5678_9ABC_DEC0;
        tag_b  = addr_b[63:26];

        repeat (3) @(negedge clk);
        check("rst_res_valid", {511'd0, res_valid_o}, 512'd0);
        check("rst_rden", {511'd0, tag_fifo_rden_o}, 512'd0);
        check("rst_rready", {511'd0, rready_o}, 512'd0);
        check("rst_addr", {448'd0, res_addr_o}, 512'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read hit: request tag = 0x40_0000_1240 >> 26 = 0x1000.
        push(1'b0, 16'd5, addr_a);
        serve(1'b1, 1'b0, 38'h1000, line_a, 2'b00);
        check("hit_hit", {511'd0, res_hit_o}, 512'd1);
        check("hit_write", {511'd0, res_write_o}, 512'd0);
        check("hit_tid", {496'd0, res_tid_o}, 512'd5);
        check("hit_err", {511'd0, res_err_o}, 512'd0);
        check("hit_addr", {448'd0, res_addr_o}, {448'd0, addr_a});
        check("hit_data", {40'd0, res_data_o}, {40'd0, line_a});
        check("hit_rready", {511'd0, rready_o}, 512'd0);
        release_result();

        // Write miss with dirty victim.
        push(1'b1, 16'h000A, addr_b);
        serve(1'b1, 1'b1, 38'h2A_AAAA_AAAA, line_b, 2'b00);
        check("wmiss_hit", {511'd0, res_hit_o}, 512'd0);
        check("wmiss_write", {511'd0, res_write_o}, 512'd1);
        check("wmiss_dirty", {511'd0, res_dirty_o}, 512'd1);
        check("wmiss_victim", {474'd0, res_victim_tag_o}, {474'd0, 38'h2A_AAAA_AAAA});
        check("wmiss_tid", {496'd0, res_tid_o}, 512'h000A);
        release_result();

        // Invalid stored line with a matching tag.
        push(1'b0, 16'h0031, addr_b);
        serve(1'b0, 1'b0, tag_b, line_a, 2'b00);
        check("inv_hit", {511'd0, res_hit_o}, 512'd0);
        check("inv_tid", {496'd0, res_tid_o}, 512'h0031);

        // Backpressure with another request already waiting in the FIFO.
        push(1'b0, 16'h0099, addr_a);
        pops_before = n_pops;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid_o || res_tid_o !== 16'h0031 || res_hit_o !== 1'b0 ||
                res_addr_o !== addr_b || rready_o !== 1'b0 || tag_fifo_rden_o !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", {511'd0, stable}, 512'd1);
        check("bp_no_pop", 512'(n_pops - pops_before), 512'd0);
        release_result();
        serve(1'b1, 1'b0, 38'h1000, line_b, 2'b00);
        check("bp_next_tid", {496'd0, res_tid_o}, 512'h0099);
        check("bp_next_hit", {511'd0, res_hit_o}, 512'd1);
        release_result();

        // Early R beat with an empty FIFO, then a SLVERR response on a matching tag.
        rdata_i  = {1'b1, 1'b0, 38'h1000, line_a};
        rresp_i  = 2'b10;
        rvalid_i = 1'b1;
        pops_before = n_pops;
        repeat (6) @(negedge clk);
        check("early_rready", {511'd0, rready_o}, 512'd0);
        check("early_no_pop", 512'(n_pops - pops_before), 512'd0);
        push(1'b0, 16'h0042, addr_a);
        serve(1'b1, 1'b0, 38'h1000, line_a, 2'b10);
        check("err_err", {511'd0, res_err_o}, 512'd1);
        check("err_hit", {511'd0, res_hit_o}, 512'd0);
        check("err_tid", {496'd0, res_tid_o}, 512'h0042);
        release_result();
        rresp_i = 2'b00;

        // Asynchronous reset while waiting for the R beat.
        push(1'b1, 16'h0077, addr_b);
        stable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rready_o) begin
                stable = 1'b1;
                break;
            end
        end
        check("rst_wait_rready", {511'd0, stable}, 512'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rready", {511'd0, rready_o}, 512'd0);
        check("arst_res_valid", {511'd0, res_valid_o}, 512'd0);
        check("arst_tid", {496'd0, res_tid_o}, 512'd0);
        check("arst_addr", {448'd0, res_addr_o}, 512'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 16'h0123, addr_a);
        serve(1'b1, 1'b1, 38'h1000, line_b, 2'b00);
        check("post_rst_hit", {511'd0, res_hit_o}, 512'd1);
        check("post_rst_tid", {496'd0, res_tid_o}, 512'h0123);
        check("post_rst_dirty", {511'd0, res_dirty_o}, 512'd1);
        release_result();
`ifdef TAG_COMPARATOR_STATS_EN
        check("stats_hit", {480'd0, hit_cnt_o}, 512'd1);
        check("stats_miss", {480'd0, miss_cnt_o}, 512'd0);
`endif
        check("no_pop_on_empty", 512'(n_bad_pops), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
